seq_detect_ctrl: RTL and testbench
==================================

Name: seq_detect_ctrl

Overview:
- Run controller for the serial bit-pattern detector. Configures the pattern and its length, arms detection on `start`, and shifts qualified serial bits into a history window.
- Counts matches and records the bit index of the latest match.
- Ends a run on a match limit or a bit limit. This replaces free-running detect-and-stop-after-N-bits operation with a handshaked, programmable sequencer.

Parameters:
- MAX_LEN, 8: maximum pattern length in bits.
- CNT_W, 16: width of the match counter and the match limit.
- IDX_W, 16: width of the bit index and the bit limit.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- d  in  1  serial data bit.
- d_valid  in  1  d is sampled on the rising edge of clk when high.
- start  in  1  single-cycle pulse; latches config and begins a run.
- abort  in  1  single-cycle pulse; ends the run immediately.
- cfg_pattern  in  MAX_LEN  pattern; bit 0 = newest bit, bit len-1 = oldest bit.
- cfg_len  in  $clog2(MAX_LEN+1)  pattern length; 0 is treated as 1, values above MAX_LEN are treated as MAX_LEN.
- cfg_overlap  in  1  1 = overlapping matches allowed; 0 = history is cleared after each match.
- cfg_max_matches  in  CNT_W  stop after this many matches; 0 = unlimited.
- cfg_max_bits  in  IDX_W  stop after this many accepted bits; 0 = unlimited.
- busy  out  1  high in state RUN.
- done  out  1  high in state DONE.
- done_reason  out  2  01 = match limit, 10 = bit limit, 11 = both on the same bit, 00 otherwise.
- match  out  1  one-cycle pulse per detected match.
- match_count  out  CNT_W  number of matches in the current/last run; saturates at all-ones.
- match_index  out  IDX_W  bit index of the most recent completing bit.

Behaviour:
- Reset (async assert, sync deassert at the top level):
  - State = IDLE.
  - All outputs = 0; history = 0; fill counter = 0; bit index = 0.
- States: IDLE, RUN, DONE.
- start in IDLE or DONE:
  - Latch all cfg_* into internal registers.
  - Clear history, fill counter, bit index, match_count, match_index and done_reason.
  - Next state = RUN.
  - start in RUN is ignored.
  - cfg_* changes during a run have no effect.
- abort in any state:
  - Next state = IDLE.
  - match_count and match_index are held; done_reason is set to 00.
  - abort takes priority over start in the same cycle.
- RUN, on each cycle with d_valid = 1:
  - history <= {history[MAX_LEN-2:0], d}.
  - fill <= min(fill+1, len).
  - bit index increments, starting at 0 for the first accepted bit.
  - Match condition: (fill+1 >= len) and the new window bits [len-1:0] equal cfg_pattern[len-1:0]. Window bits above len are ignored.
- On a match:
  - match pulses high on the following cycle (1-cycle latency from the sampling edge).
  - match_count increments, saturating at all-ones.
  - match_index <= index of the completing bit.
  - If overlap = 0, fill <= 0 so the next match needs len fresh bits.
- Cycles with d_valid = 0: no state change and no match.
- Termination, evaluated on the same accepted bit:
  - Match limit reached: cfg_max_matches != 0 and the updated count == cfg_max_matches.
  - Bit limit reached: cfg_max_bits != 0 and (bit index + 1) == cfg_max_bits.
  - Either condition → next state = DONE, with done_reason set per the Ports encoding.
  - A match on the terminating bit still pulses match.
- DONE: done = 1 and busy = 0. Outputs are held until start or abort; further d_valid bits are ignored.
- Reset mid-run: everything returns to reset values immediately. No match pulse may appear after rst_n is asserted.

Test Plan:
- len=4, pattern=4'b0111, overlap=1, limits 0; stream 0,1,1,1,0,1,1,1 → match after bits 3 and 7; match_index=3 then 7; match_count=2; busy stays 1.
- len=3, pattern=3'b101, stream 1,0,1,0,1: overlap=1 → 2 matches (idx 2, 4); overlap=0 → 1 match (idx 2).
- cfg_max_matches=2 with 0111 repeated three times → DONE after bit 7, done_reason=01, the third occurrence is not counted, match_count=2.
- cfg_max_bits=4 with stream 0,1,1,1 → match at idx 3 plus DONE with done_reason=11. Also assert start and abort together in RUN → IDLE, done_reason=00, match_count unchanged.
- Drop d_valid every other cycle during 0111 → same match result as the continuous case. Then assert rst_n low mid-run → busy=0, match_count=0, no match pulse.
- cfg_len=0 with pattern bit0=1 → every 1 bit matches. cfg_len=15 with MAX_LEN=8 → behaves as len=8.

Source files
------------

// File: rtl/seq_detect_ctrl.sv
// Run controller for a serial bit-pattern detector: arms on start, slides qualified bits
// through a history window, counts matches and ends the run on a match or bit limit.
module seq_detect_ctrl #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 16,
    parameter int IDX_W   = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         d,
    input  logic                         d_valid,
    input  logic                         start,
    input  logic                         abort,
    input  logic [MAX_LEN-1:0]           cfg_pattern,
    input  logic [$clog2(MAX_LEN+1)-1:0] cfg_len,
    input  logic                         cfg_overlap,
    input  logic [CNT_W-1:0]             cfg_max_matches,
    input  logic [IDX_W-1:0]             cfg_max_bits,
    output logic                         busy,
    output logic                         done,
    output logic [1:0]                   done_reason,
    output logic                         match,
    output logic [CNT_W-1:0]             match_count,
    output logic [IDX_W-1:0]             match_index
);
    localparam int LEN_W = $clog2(MAX_LEN+1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [LEN_W-1:0]   len_r;
    logic [MAX_LEN-1:0] pat_r;
    logic               ovl_r;
    logic [CNT_W-1:0]   maxm_r;
    logic [IDX_W-1:0]   maxb_r;
    logic [MAX_LEN-2:0] hist_r;
    logic [LEN_W-1:0]   fill_r;
    logic [IDX_W-1:0]   bit_idx_r;
    logic [CNT_W-1:0]   match_count_r;
    logic [IDX_W-1:0]   match_index_r;
    logic [1:0]         done_reason_r;
    logic               match_p1;

    logic [MAX_LEN-1:0] win;
    logic [MAX_LEN-1:0] mask;
    logic               fill_ok;
    logic               hit;
    logic               accept;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               lim_m;
    logic               lim_b;
    logic               term;

    function automatic logic [MAX_LEN-1:0] len_mask(input logic [LEN_W-1:0] len);
        logic [MAX_LEN-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if (i < int'(len)) m[i] = 1'b1;
        end
        return m;
    endfunction

    // Length 0 behaves as 1, anything above MAX_LEN is clamped.
    function automatic logic [LEN_W-1:0] norm_len(input logic [LEN_W-1:0] len);
        if (len == '0)
            return LEN_W'(1);
        else if (int'(len) > MAX_LEN)
            return LEN_W'(MAX_LEN);
        else
            return len;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    always_comb begin
        win     = {hist_r, d};
        mask    = len_mask(len_r);
        fill_ok = ({1'b0, fill_r} + (LEN_W+1)'(1)) >= {1'b0, len_r};
        hit     = fill_ok && ((win & mask) == (pat_r & mask));
        accept  = (state == S_RUN) && d_valid && !abort;
        cnt_nxt = hit ? sat_inc(match_count_r) : match_count_r;
        lim_m   = (maxm_r != '0) && (cnt_nxt == maxm_r);
        lim_b   = (maxb_r != '0) && ((bit_idx_r + IDX_W'(1)) == maxb_r);
        term    = accept && (lim_m || lim_b);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (abort) begin
            state_nxt = S_IDLE;
        end else begin
            case (state)
                S_IDLE:  if (start) state_nxt = S_RUN;
                S_RUN:   if (term)  state_nxt = S_DONE;
                S_DONE:  if (start) state_nxt = S_RUN;
                default: state_nxt = S_IDLE;
            endcase
        end
    end

    // Sampling edge: window shift, match registration and termination cause.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            len_r         <= LEN_W'(1);
            pat_r         <= '0;
            ovl_r         <= 1'b0;
            maxm_r        <= '0;
            maxb_r        <= '0;
            hist_r        <= '0;
            fill_r        <= '0;
            bit_idx_r     <= '0;
            match_count_r <= '0;
            match_index_r <= '0;
            done_reason_r <= 2'b00;
            match_p1      <= 1'b0;
        end else begin
            match_p1 <= 1'b0;
            if (abort) begin
                done_reason_r <= 2'b00;
            end else if (start && (state != S_RUN)) begin
                len_r         <= norm_len(cfg_len);
                pat_r         <= cfg_pattern;
                ovl_r         <= cfg_overlap;
                maxm_r        <= cfg_max_matches;
                maxb_r        <= cfg_max_bits;
                hist_r        <= '0;
                fill_r        <= '0;
                bit_idx_r     <= '0;
                match_count_r <= '0;
                match_index_r <= '0;
                done_reason_r <= 2'b00;
            end else if (accept) begin
                hist_r    <= win[MAX_LEN-2:0];
                bit_idx_r <= bit_idx_r + IDX_W'(1);
                if (hit && !ovl_r)
                    fill_r <= '0;
                else if (fill_r < len_r)
                    fill_r <= fill_r + LEN_W'(1);
                if (hit) begin
                    match_p1      <= 1'b1;
                    match_count_r <= cnt_nxt;
                    match_index_r <= bit_idx_r;
                end
                if (term)
                    done_reason_r <= {lim_b, lim_m};
            end
        end
    end

    assign busy        = (state == S_RUN);
    assign done        = (state == S_DONE);
    assign done_reason = done_reason_r;
    assign match       = match_p1;
    assign match_count = match_count_r;
    assign match_index = match_index_r;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: table vectors, hand-written corner sequences and a
// randomized run compared against a queue-based reference model.
module tb_seq_detect_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 16;
    localparam int IDX_W   = 16;
    localparam int LEN_W   = $clog2(MAX_LEN+1);

    logic               clk;
    logic               rst_n;
    logic               d;
    logic               d_valid;
    logic               start;
    logic               abort;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LEN_W-1:0]   cfg_len;
    logic               cfg_overlap;
    logic [CNT_W-1:0]   cfg_max_matches;
    logic [IDX_W-1:0]   cfg_max_bits;
    logic               busy;
    logic               done;
    logic [1:0]         done_reason;
    logic               match;
    logic [CNT_W-1:0]   match_count;
    logic [IDX_W-1:0]   match_index;

    seq_detect_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .IDX_W(IDX_W)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .d_valid(d_valid), .start(start), .abort(abort),
        .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
        .cfg_max_matches(cfg_max_matches), .cfg_max_bits(cfg_max_bits),
        .busy(busy), .done(done), .done_reason(done_reason), .match(match),
        .match_count(match_count), .match_index(match_index)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Reference model: the accepted bits since the last fresh start live in a queue.
    int               m_state;   // 0 idle, 1 run, 2 done
    bit               m_q[$];
    int               m_len;
    logic [MAX_LEN-1:0] m_pat;
    bit               m_ovl;
    int               m_maxm, m_maxb, m_idx, m_cnt, m_mi, m_reason;
    bit               m_match;

    function void m_reset();
        m_state = 0; m_q.delete(); m_len = 1; m_pat = '0; m_ovl = 0;
        m_maxm = 0; m_maxb = 0; m_idx = 0; m_cnt = 0; m_mi = 0; m_reason = 0; m_match = 0;
    endfunction

    function void model_step(input bit dd, input bit dv, input bit st, input bit ab);
        bit hit, lm, lb;
        m_match = 0;
        if (ab) begin
            m_state = 0; m_reason = 0;
        end else if (st && m_state != 1) begin
            m_len  = (cfg_len == 0) ? 1 : ((int'(cfg_len) > MAX_LEN) ? MAX_LEN : int'(cfg_len));
            m_pat  = cfg_pattern; m_ovl = cfg_overlap;
            m_maxm = int'(cfg_max_matches); m_maxb = int'(cfg_max_bits);
            m_q.delete(); m_idx = 0; m_cnt = 0; m_mi = 0; m_reason = 0; m_state = 1;
        end else if (m_state == 1 && dv) begin
            m_q.push_back(dd);
            hit = (m_q.size() >= m_len);
            for (int k = 0; k < m_len; k++)
                if (hit && (m_q[m_q.size()-1-k] != m_pat[k])) hit = 0;
            if (m_q.size() > MAX_LEN) void'(m_q.pop_front());
            if (hit) begin
                m_match = 1;
                if (m_cnt < (2**CNT_W)-1) m_cnt++;
                m_mi = m_idx;
                if (!m_ovl) m_q.delete();
            end
            lm = (m_maxm != 0) && (m_cnt == m_maxm);
            lb = (m_maxb != 0) && (m_idx + 1 == m_maxb);
            m_idx++;
            if (lm || lb) begin
                m_state  = 2;
                m_reason = (lb ? 2 : 0) + (lm ? 1 : 0);
            end
        end
    endfunction

    task automatic cyc(input bit dd, input bit dv, input bit st, input bit ab);
        d = dd; d_valid = dv; start = st; abort = ab;
        @(posedge clk);
        if (rst_n) model_step(dd, dv, st, ab);
        else m_reset();
        #1;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " busy"},   32'(busy),        32'(m_state == 1));
        chk({tag, " done"},   32'(done),        32'(m_state == 2));
        chk({tag, " reason"}, 32'(done_reason), 32'(m_reason));
        chk({tag, " match"},  32'(match),       32'(m_match));
        chk({tag, " count"},  32'(match_count), 32'(m_cnt));
        chk({tag, " index"},  32'(match_index), 32'(m_mi));
    endtask

    task automatic set_cfg(input int len, input logic [MAX_LEN-1:0] pat, input bit ovl,
                           input int maxm, input int maxb);
        cfg_len = LEN_W'(len); cfg_pattern = pat; cfg_overlap = ovl;
        cfg_max_matches = CNT_W'(maxm); cfg_max_bits = IDX_W'(maxb);
    endtask

    typedef struct {
        int               cfg_len;
        logic [MAX_LEN-1:0] pat;
        bit               ovl;
        int               maxm;
        int               maxb;
        string            stream;   // oldest bit first
        string            mask;     // '1' where a match pulse follows that bit
        int               e_cnt;
        int               e_idx;
        bit               e_busy;
        bit               e_done;
        int               e_reason;
    } vec_t;

    vec_t vt[8];

    task automatic run_vec(input vec_t v, input int vi);
        string tag;
        tag = $sformatf("vec%0d", vi);
        cyc(0, 0, 0, 1);
        chk({tag, " abort busy"},   32'(busy), 0);
        chk({tag, " abort reason"}, 32'(done_reason), 0);
        set_cfg(v.cfg_len, v.pat, v.ovl, v.maxm, v.maxb);
        cyc(0, 0, 1, 0);
        chk({tag, " start busy"},  32'(busy), 1);
        chk({tag, " start count"}, 32'(match_count), 0);
        for (int i = 0; i < v.stream.len(); i++) begin
            cyc(v.stream[i] == 8'h31, 1, 0, 0);
            chk($sformatf("%s match bit%0d", tag, i), 32'(match), 32'(v.mask[i] == 8'h31));
        end
        chk({tag, " count"},  32'(match_count), 32'(v.e_cnt));
        chk({tag, " index"},  32'(match_index), 32'(v.e_idx));
        chk({tag, " busy"},   32'(busy),        32'(v.e_busy));
        chk({tag, " done"},   32'(done),        32'(v.e_done));
        chk({tag, " reason"}, 32'(done_reason), 32'(v.e_reason));
    endtask

    initial begin
        vt[0] = '{4, 8'b0111,     1'b1, 0, 0, "01110111",         "00010001",         2, 7,  1'b1, 1'b0, 0};
        vt[1] = '{3, 8'b101,      1'b1, 0, 0, "10101",            "00101",            2, 4,  1'b1, 1'b0, 0};
        vt[2] = '{3, 8'b101,      1'b0, 0, 0, "10101",            "00100",            1, 2,  1'b1, 1'b0, 0};
        vt[3] = '{4, 8'b0111,     1'b1, 2, 0, "011101110111",     "000100010000",     2, 7,  1'b0, 1'b1, 1};
        vt[4] = '{4, 8'b0111,     1'b1, 1, 4, "0111",             "0001",             1, 3,  1'b0, 1'b1, 3};
        vt[5] = '{0, 8'b00000001, 1'b1, 0, 0, "1011001",          "1011001",          4, 6,  1'b1, 1'b0, 0};
        vt[6] = '{15, 8'b10110011, 1'b1, 0, 0, "0011001110110011", "0000000000000001", 1, 15, 1'b1, 1'b0, 0};
        vt[7] = '{4, 8'b0111,     1'b1, 0, 3, "01110",            "00000",            0, 0,  1'b0, 1'b1, 2};

        d = 0; d_valid = 0; start = 0; abort = 0; rst_n = 1'b1;
        set_cfg(0, '0, 0, 0, 0);
        #1 rst_n = 1'b0;
        m_reset();
        #1;
        check_model("reset");
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;

        for (int i = 0; i < 8; i++) run_vec(vt[i], i);

        // start ignored in RUN (with changed cfg), then start+abort together.
        cyc(0, 0, 0, 1);
        set_cfg(4, 8'b0111, 1, 0, 0);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        chk("ign count1", 32'(match_count), 1);
        set_cfg(1, 8'hFF, 0, 1, 1);
        cyc(0, 0, 1, 0);
        chk("ign busy", 32'(busy), 1);
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        chk("ign count2", 32'(match_count), 2);
        cyc(0, 0, 1, 1);
        chk("stab busy",   32'(busy),        0);
        chk("stab done",   32'(done),        0);
        chk("stab reason", 32'(done_reason), 0);
        chk("stab count",  32'(match_count), 2);
        chk("stab index",  32'(match_index), 7);

        // d_valid dropped every other cycle; idle cycles carry d=1 that must be ignored.
        set_cfg(4, 8'b0111, 1, 0, 0);
        cyc(0, 0, 1, 0);
        begin
            string s, mk;
            s = "01110111"; mk = "00010001";
            for (int i = 0; i < 8; i++) begin
                cyc(s[i] == 8'h31, 1, 0, 0);
                chk($sformatf("gap match bit%0d", i), 32'(match), 32'(mk[i] == 8'h31));
                cyc(1, 0, 0, 0);
                chk($sformatf("gap idle%0d", i), 32'(match), 0);
            end
        end
        chk("gap count", 32'(match_count), 2);
        chk("gap index", 32'(match_index), 7);

        // Reset asserted mid-cycle just before a completing bit is sampled.
        cyc(0, 0, 0, 1);
        cyc(0, 0, 1, 0);
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0); cyc(1, 1, 0, 0); cyc(1, 1, 0, 0);
        chk("prerst count", 32'(match_count), 1);
        d = 1; d_valid = 1;
        #2 rst_n = 1'b0;
        m_reset();
        #1;
        chk("rst busy",  32'(busy),        0);
        chk("rst count", 32'(match_count), 0);
        chk("rst index", 32'(match_index), 0);
        chk("rst match", 32'(match),       0);
        @(posedge clk);
        #1;
        chk("rst match2", 32'(match), 0);
        chk("rst busy2",  32'(busy),  0);
        @(negedge clk) begin rst_n = 1'b1; d_valid = 0; end
        @(posedge clk);
        #1;
        check_model("postrst");

        for (int n = 0; n < 3000; n++) begin
            int ln;
            ln = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 15) : $urandom_range(0, 3);
            set_cfg(ln, MAX_LEN'($urandom), 1'($urandom_range(0, 1)),
                    $urandom_range(0, 4), ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 30));
            cyc(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0,
                $urandom_range(0, 29) == 0, $urandom_range(0, 99) == 0);
            check_model($sformatf("rnd%0d", n));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
